// File: rtl/fpu_responder.sv
// fpu_responder: single-precision FPU responder. Requests are unpacked, computed and
// normalized in three pipeline stages; fpuout/fflags/fpu_done update three edges after acceptance.
module fpu_responder #(
  parameter logic [31:0] CANON_NAN  = 32'h7FC00000,
  parameter bit          ENABLE_MUL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fpu1in,
  input  logic [31:0] fpu2in,
  input  logic [4:0]  fpuen,
  output logic [31:0] fpuout,
  output logic        fpu_done,
  output logic [4:0]  fflags
);

  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_MUL = 5'h03;
  localparam logic [4:0] OP_MIN = 5'h04, OP_MAX = 5'h05;
  localparam logic [4:0] OP_EQ  = 5'h06, OP_LT  = 5'h07, OP_LE  = 5'h08;
  localparam logic [4:0] OP_NEG = 5'h09, OP_ABS = 5'h0A;

  // Stage 1: capture the request with denormal operands flushed to signed zero
  logic        s1_valid_d, s1_valid_q;
  logic [4:0]  s1_op_d, s1_op_q;
  logic [31:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;

  always_comb begin
    s1_valid_d = (fpuen != 5'd0);
    s1_op_d    = fpuen;
    s1_a_d     = (fpu1in[30:23] == 8'd0) ? {fpu1in[31], 31'd0} : fpu1in;
    s1_b_d     = (fpu2in[30:23] == 8'd0) ? {fpu2in[31], 31'd0} : fpu2in;
  end

  // Operand classification, alignment, add/sub, multiply and compare datapath
  logic        a_sign, b_sign, b_sign_eff, eff_sub, a_big;
  logic [7:0]  a_exp, b_exp, exp_big, exp_diff;
  logic [30:0] a_mag, b_mag;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        any_nan, any_snan, both_zero;
  logic [23:0] man_a, man_b, man_big, man_small;
  logic [95:0] shifted;
  logic [47:0] small_al, prod;
  logic        sticky, add_sign;
  logic [48:0] sum;
  logic        a_lt_b, b_lt_a, a_eq_b, pick_a_min, pick_a_max;

  always_comb begin
    a_sign     = s1_a_q[31];
    b_sign     = s1_b_q[31];
    a_exp      = s1_a_q[30:23];
    b_exp      = s1_b_q[30:23];
    a_mag      = s1_a_q[30:0];
    b_mag      = s1_b_q[30:0];
    a_nan      = (a_exp == 8'hFF) && (s1_a_q[22:0] != 23'd0);
    b_nan      = (b_exp == 8'hFF) && (s1_b_q[22:0] != 23'd0);
    a_snan     = a_nan && !s1_a_q[22];
    b_snan     = b_nan && !s1_b_q[22];
    a_inf      = (a_exp == 8'hFF) && (s1_a_q[22:0] == 23'd0);
    b_inf      = (b_exp == 8'hFF) && (s1_b_q[22:0] == 23'd0);
    a_zero     = (a_exp == 8'd0);
    b_zero     = (b_exp == 8'd0);
    any_nan    = a_nan || b_nan;
    any_snan   = a_snan || b_snan;
    both_zero  = a_zero && b_zero;
    man_a      = a_zero ? 24'd0 : {1'b1, s1_a_q[22:0]};
    man_b      = b_zero ? 24'd0 : {1'b1, s1_b_q[22:0]};

    b_sign_eff = b_sign ^ (s1_op_q == OP_SUB);
    eff_sub    = a_sign ^ b_sign_eff;
    a_big      = (a_mag >= b_mag);
    exp_big    = a_big ? a_exp : b_exp;
    exp_diff   = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
    man_big    = a_big ? man_a : man_b;
    man_small  = a_big ? man_b : man_a;
    shifted    = {man_small, 72'd0} >> exp_diff;
    small_al   = shifted[95:48];
    sticky     = (shifted[47:0] != 48'd0) || ((exp_diff > 8'd71) && (man_small != 24'd0));
    // Subtracting the sticky bit makes plain truncation of the difference land on the RTZ value
    if (eff_sub)
      sum = {1'b0, man_big, 24'd0} - {1'b0, small_al} - {48'd0, sticky};
    else
      sum = {1'b0, man_big, 24'd0} + {1'b0, small_al};
    if (sum == 49'd0)
      add_sign = a_sign & b_sign_eff;
    else
      add_sign = a_big ? a_sign : b_sign_eff;

    prod = {24'd0, man_a} * {24'd0, man_b};

    a_eq_b = (s1_a_q == s1_b_q) || both_zero;
    if (a_sign != b_sign) begin
      a_lt_b = a_sign & ~both_zero;
      b_lt_a = b_sign & ~both_zero;
    end else if (!a_sign) begin
      a_lt_b = a_mag < b_mag;
      b_lt_a = b_mag < a_mag;
    end else begin
      a_lt_b = a_mag > b_mag;
      b_lt_a = b_mag > a_mag;
    end
    pick_a_min = a_lt_b || (both_zero && a_sign);
    pick_a_max = b_lt_a || (both_zero && !a_sign);
  end

  // Stage 2: either a finished special result or an unnormalized sign/exponent/mantissa
  logic        s2_valid_d, s2_valid_q, s2_special_d, s2_special_q;
  logic [31:0] s2_result_d, s2_result_q;
  logic [4:0]  s2_flags_d, s2_flags_q;
  logic        s2_sign_d, s2_sign_q;
  logic [11:0] s2_exp_d, s2_exp_q;
  logic [48:0] s2_man_d, s2_man_q;

  always_comb begin
    s2_valid_d   = s1_valid_q;
    s2_special_d = 1'b1;
    s2_result_d  = 32'd0;
    s2_flags_d   = 5'd0;
    s2_sign_d    = 1'b0;
    s2_exp_d     = 12'd0;
    s2_man_d     = 49'd0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        if (any_nan) begin
          s2_result_d   = CANON_NAN;
          s2_flags_d[4] = any_snan;
        end else if (a_inf && b_inf && eff_sub) begin
          s2_result_d   = CANON_NAN;
          s2_flags_d[4] = 1'b1;
        end else if (a_inf) begin
          s2_result_d = {a_sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
          s2_result_d = {b_sign_eff, 8'hFF, 23'd0};
        end else begin
          s2_special_d  = 1'b0;
          s2_sign_d     = add_sign;
          s2_exp_d      = {4'd0, exp_big};
          s2_man_d      = sum;
          s2_flags_d[0] = sticky;
        end
      end
      OP_MUL: begin
        if (!ENABLE_MUL) begin
          s2_flags_d[4] = 1'b1;
        end else if (any_nan) begin
          s2_result_d   = CANON_NAN;
          s2_flags_d[4] = any_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          s2_result_d   = CANON_NAN;
          s2_flags_d[4] = 1'b1;
        end else if (a_inf || b_inf) begin
          s2_result_d = {a_sign ^ b_sign, 8'hFF, 23'd0};
        end else begin
          s2_special_d = 1'b0;
          s2_sign_d    = a_sign ^ b_sign;
          s2_exp_d     = {4'd0, a_exp} + {4'd0, b_exp} - 12'd126;
          s2_man_d     = {1'b0, prod};
        end
      end
      OP_MIN, OP_MAX: begin
        s2_flags_d[4] = any_snan;
        if (a_nan && b_nan)
          s2_result_d = CANON_NAN;
        else if (a_nan)
          s2_result_d = s1_b_q;
        else if (b_nan)
          s2_result_d = s1_a_q;
        else if ((s1_op_q == OP_MIN) ? pick_a_min : pick_a_max)
          s2_result_d = s1_a_q;
        else
          s2_result_d = s1_b_q;
      end
      OP_EQ: begin
        s2_result_d   = {31'd0, ~any_nan & a_eq_b};
        s2_flags_d[4] = any_snan;
      end
      OP_LT: begin
        s2_result_d   = {31'd0, ~any_nan & a_lt_b};
        s2_flags_d[4] = any_nan;
      end
      OP_LE: begin
        s2_result_d   = {31'd0, ~any_nan & (a_lt_b | a_eq_b)};
        s2_flags_d[4] = any_nan;
      end
      OP_NEG: s2_result_d = a_nan ? CANON_NAN : {~a_sign, s1_a_q[30:0]};
      OP_ABS: s2_result_d = a_nan ? CANON_NAN : {1'b0, s1_a_q[30:0]};
      default: s2_flags_d[4] = 1'b1;
    endcase
  end

  // Stage 3: normalize, truncate and apply overflow/underflow clamping
  logic        s3_valid_d, s3_valid_q;
  logic [31:0] s3_result_d, s3_result_q;
  logic [4:0]  s3_flags_d, s3_flags_q;
  logic [5:0]  lead;
  logic [47:0] norm;
  logic [11:0] exp_n;
  logic        nx;

  always_comb begin
    lead = 6'd0;
    for (int i = 0; i < 49; i++)
      if (s2_man_q[i]) lead = 6'(i);
    norm  = 48'(s2_man_q << (6'd48 - lead));
    exp_n = s2_exp_q - 12'd47 + {6'd0, lead};
    nx    = s2_flags_q[0] | (norm[24:0] != 25'd0);

    s3_valid_d  = s2_valid_q;
    s3_result_d = s2_result_q;
    s3_flags_d  = s2_flags_q;
    if (!s2_special_q) begin
      if (s2_man_q == 49'd0) begin
        s3_result_d = {s2_sign_q, 31'd0};
      end else if ($signed(exp_n) >= $signed(12'd255)) begin
        s3_result_d = {s2_sign_q, 31'h7F7FFFFF};
        s3_flags_d  = 5'b00101;
      end else if ($signed(exp_n) <= $signed(12'd0)) begin
        s3_result_d = {s2_sign_q, 31'd0};
        s3_flags_d  = 5'b00011;
      end else begin
        s3_result_d = {s2_sign_q, exp_n[7:0], norm[47:25]};
        s3_flags_d  = {4'd0, nx};
      end
    end
  end

  logic [31:0] fpuout_d, fpuout_q;
  logic [4:0]  fflags_d, fflags_q;
  logic        fpu_done_d, fpu_done_q;

  always_comb begin
    fpu_done_d = s3_valid_q;
    fpuout_d   = s3_valid_q ? s3_result_q : fpuout_q;
    fflags_d   = s3_valid_q ? s3_flags_q : fflags_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 5'd0;
      s1_a_q       <= 32'd0;
      s1_b_q       <= 32'd0;
      s2_valid_q   <= 1'b0;
      s2_special_q <= 1'b0;
      s2_result_q  <= 32'd0;
      s2_flags_q   <= 5'd0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= 12'd0;
      s2_man_q     <= 49'd0;
      s3_valid_q   <= 1'b0;
      s3_result_q  <= 32'd0;
      s3_flags_q   <= 5'd0;
      fpuout_q     <= 32'd0;
      fflags_q     <= 5'd0;
      fpu_done_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_special_q <= s2_special_d;
      s2_result_q  <= s2_result_d;
      s2_flags_q   <= s2_flags_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_man_q     <= s2_man_d;
      s3_valid_q   <= s3_valid_d;
      s3_result_q  <= s3_result_d;
      s3_flags_q   <= s3_flags_d;
      fpuout_q     <= fpuout_d;
      fflags_q     <= fflags_d;
      fpu_done_q   <= fpu_done_d;
    end
  end

  assign fpuout   = fpuout_q;
  assign fflags   = fflags_q;
  assign fpu_done = fpu_done_q;

endmodule

// File: tb/tb_fpu_responder.sv
// tb_fpu_responder: directed self-checking bench for fpu_responder with hand-computed
// results, covering latency, back-to-back issue, special values, flags and reset.
module tb_fpu_responder;

  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_MUL = 5'h03;
  localparam logic [4:0] OP_MIN = 5'h04, OP_MAX = 5'h05;
  localparam logic [4:0] OP_EQ  = 5'h06, OP_LT  = 5'h07, OP_LE  = 5'h08;
  localparam logic [4:0] OP_NEG = 5'h09, OP_ABS = 5'h0A;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fpu1in, fpu2in;
  logic [4:0]  fpuen;
  logic [31:0] fpuout;
  logic        fpu_done;
  logic [4:0]  fflags;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  fpu_responder dut (
    .clk      (clk),
    .reset    (reset),
    .fpu1in   (fpu1in),
    .fpu2in   (fpu2in),
    .fpuen    (fpuen),
    .fpuout   (fpuout),
    .fpu_done (fpu_done),
    .fflags   (fflags)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives a request at a falling edge so it is accepted on the following rising edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    fpuen  = op;
    fpu1in = a;
    fpu2in = b;
  endtask

  // Issues one request at edge N and checks that it completes at exactly edge N+3.
  task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input logic [4:0] expFlags);
    applyStimulus(op, a, b);
    @(negedge clk);
    fpuen  = 5'd0;
    fpu1in = 32'hDEADBEEF;
    fpu2in = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, ".early_done"}, {31'd0, fpu_done}, 32'd0);
    @(negedge clk);
    checkOutput({tag, ".done"}, {31'd0, fpu_done}, 32'd1);
    checkOutput({tag, ".result"}, fpuout, expRes);
    checkOutput({tag, ".flags"}, {27'd0, fflags}, {27'd0, expFlags});
  endtask

  initial begin
    int doneSeen;
    int changes;
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    int changes;
    reset  = 1'b0;
    fpuen  = 5'd0;
    fpu1in = 32'd0;
    fpu2in = 32'd0;
    #1;
    checkOutput("reset.fpuout", fpuout, 32'd0);
    checkOutput("reset.done", {31'd0, fpu_done}, 32'd0);
    checkOutput("reset.flags", {27'd0, fflags}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp("fadd_basic", OP_ADD, 32'h3FC00000, 32'h40100000, 32'h40700000, 5'b00000);

    // Back-to-back FMUL then FSUB complete on consecutive edges.
    applyStimulus(OP_MUL, 32'h40400000, 32'h3F000000);
    applyStimulus(OP_SUB, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    fpuen = 5'd0;
    @(negedge clk);
    checkOutput("b2b.early_done", {31'd0, fpu_done}, 32'd0);
    @(negedge clk);
    checkOutput("b2b.done0", {31'd0, fpu_done}, 32'd1);
    checkOutput("b2b.result0", fpuout, 32'h3FC00000);
    @(negedge clk);
    checkOutput("b2b.done1", {31'd0, fpu_done}, 32'd1);
    checkOutput("b2b.result1", fpuout, 32'h00000000);
    @(negedge clk);
    checkOutput("b2b.done_drop", {31'd0, fpu_done}, 32'd0);
    checkOutput("b2b.hold", fpuout, 32'h00000000);

    runOp("fmul_overflow", OP_MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 5'b00101);
    runOp("fmul_underflow", OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 5'b00011);
    runOp("fsub_inf_inf", OP_SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000);
    runOp("fmul_zero_inf", OP_MUL, 32'h00000000, 32'hFF800000, 32'h7FC00000, 5'b10000);
    runOp("flt_qnan", OP_LT, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'b10000);
    runOp("fmin_qnan", OP_MIN, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 5'b00000);
    runOp("feq_zeros", OP_EQ, 32'h80000000, 32'h00000000, 32'h00000001, 5'b00000);
    runOp("illegal_1f", 5'h1F, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'b10000);

    runOp("fadd_cancel", OP_ADD, 32'hBF800000, 32'h3F800000, 32'h00000000, 5'b00000);
    runOp("fadd_negzeros", OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 5'b00000);
    runOp("fsub_negzero_poszero", OP_SUB, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000);
    runOp("fadd_inexact", OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
    runOp("fsub_exact", OP_SUB, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 5'b00000);
    runOp("fsub_guard", OP_SUB, 32'h3F800000, 32'h33000000, 32'h3F7FFFFF, 5'b00001);
    runOp("fsub_sticky", OP_SUB, 32'h3F800000, 32'h00800000, 32'h3F7FFFFF, 5'b00001);
    runOp("fadd_inf_fin", OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'b00000);
    runOp("fadd_denorm", OP_ADD, 32'h00400000, 32'h3F800000, 32'h3F800000, 5'b00000);
    runOp("fmul_neg", OP_MUL, 32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000);
    runOp("fmax_zeros", OP_MAX, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000);
    runOp("fmin_zeros", OP_MIN, 32'h00000000, 32'h80000000, 32'h80000000, 5'b00000);
    runOp("fle_equal", OP_LE, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'b00000);
    runOp("flt_negs", OP_LT, 32'hC0000000, 32'hBF800000, 32'h00000001, 5'b00000);
    runOp("feq_snan", OP_EQ, 32'h7F800001, 32'h3F800000, 32'h00000000, 5'b10000);
    runOp("fneg", OP_NEG, 32'h3F800000, 32'h00000000, 32'hBF800000, 5'b00000);
    runOp("fabs", OP_ABS, 32'hC0400000, 32'h00000000, 32'h40400000, 5'b00000);

    // Two requests in flight are discarded by an asynchronous reset.
    applyStimulus(OP_ADD, 32'h3FC00000, 32'h40100000);
    applyStimulus(OP_MUL, 32'h40400000, 32'h3F000000);
    @(negedge clk);
    fpuen = 5'd0;
    reset = 1'b0;
    #1;
    checkOutput("midreset.fpuout", fpuout, 32'd0);
    checkOutput("midreset.flags", {27'd0, fflags}, 32'd0);
    checkOutput("midreset.done", {31'd0, fpu_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fpu_done) doneSeen++;
    end
    checkOutput("midreset.no_done", doneSeen, 0);
    checkOutput("midreset.fpuout_after", fpuout, 32'd0);

    runOp("after_reset", OP_MAX, 32'h40000000, 32'hC0000000, 32'h40000000, 5'b00000);

    doneSeen = 0;
    changes  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fpu_done) doneSeen++;
      if (fpuout !== 32'h40000000) changes++;
    end
    checkOutput("idle.no_done", doneSeen, 0);
    checkOutput("idle.hold_changes", changes, 0);
    checkOutput("idle.fpuout", fpuout, 32'h40000000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
